// File: rtl/ring_collect.sv
// Collects client writes into a DEPTH-entry buffer and drains them in order to a downstream FIFO.
// Optional OVERFLOW flag is built when RING_COLLECT_OVERFLOW_EN is defined.
module ring_collect #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WREN,
  input  logic [WIDTH-1:0] WRDATA,
  input  logic             FLUSH,
  input  logic             FINISH,
  output logic             FULL,
  output logic [WIDTH-1:0] FIFO_WRDATA,
  output logic             FIFO_WREN,
  input  logic             FIFO_WRFULL,
  output logic             FIFO_DONE
`ifdef RING_COLLECT_OVERFLOW_EN
  ,
  output logic             OVERFLOW
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    ridx;
  logic             finish_pending;
  logic [WIDTH-1:0] data [DEPTH];

  logic             full_raw;
  logic             wr_ok;
  logic             emit;
  logic             last;
  logic [CW-1:0]    cnt_next;

  assign full_raw = (state != FILL) | (cnt == DEPTH_C);
  assign wr_ok    = WREN & ~full_raw;
  assign emit     = (state == DRAIN) & ~FIFO_WRFULL;
  assign last     = (ridx == (cnt - CW'(1)));
  assign cnt_next = cnt + CW'(wr_ok);

  // Outputs are held quiet while RESET is asserted so nothing leaks downstream on the reset cycle.
  assign FULL        = ~RESET & full_raw;
  assign FIFO_WREN   = ~RESET & emit;
  assign FIFO_DONE   = ~RESET & (state == DONE);
  assign FIFO_WRDATA = data[ridx[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (wr_ok) data[cnt[AW-1:0]] <= WRDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= FILL;
      cnt            <= '0;
      ridx           <= '0;
      finish_pending <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          cnt <= cnt_next;
          if (FINISH) finish_pending <= 1'b1;
          // A write landing in the same cycle as FLUSH/FINISH is part of the drain.
          if ((cnt_next == DEPTH_C) || ((FLUSH | FINISH) && (cnt_next != '0)))
            state <= DRAIN;
          else if (FINISH)
            state <= DONE;
        end
        DRAIN: begin
          if (FINISH) finish_pending <= 1'b1;
          if (emit) begin
            if (last) begin
              cnt   <= '0;
              ridx  <= '0;
              state <= (finish_pending | FINISH) ? DONE : FILL;
            end else begin
              ridx <= ridx + CW'(1);
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef RING_COLLECT_OVERFLOW_EN
  logic overflow;

  always_ff @(posedge CLK) begin
    if (RESET)                overflow <= 1'b0;
    else if (WREN & full_raw) overflow <= 1'b1;
  end

  assign OVERFLOW = overflow;
`endif

endmodule

// File: tb/tb_ring_collect.sv
// Bench for ring_collect: queue-based reference model checked every cycle, directed scenarios
// pinned with literal expectations, then a randomized phase.
module tb_ring_collect;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wren = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic             flush = 1'b0;
  logic             finish = 1'b0;
  logic             wrfull = 1'b0;
  logic             full;
  logic [WIDTH-1:0] fdata;
  logic             fwren;
  logic             fdone;
`ifdef RING_COLLECT_OVERFLOW_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  ring_collect #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(clk),
    .RESET(rst),
    .WREN(wren),
    .WRDATA(wdata),
    .FLUSH(flush),
    .FINISH(finish),
    .FULL(full),
    .FIFO_WRDATA(fdata),
    .FIFO_WREN(fwren),
    .FIFO_WRFULL(wrfull),
    .FIFO_DONE(fdone)
`ifdef RING_COLLECT_OVERFLOW_EN
    ,
    .OVERFLOW(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: pending entries as a queue, mode as a few flags.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] mlog[$];
  logic [WIDTH-1:0] dlog[$];
  bit m_drain, m_done, m_fin, m_ovf;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_drain = 0; m_done = 0; m_fin = 0; m_ovf = 0;
    end else if (m_done) begin
      if (wren) m_ovf = 1;
    end else if (m_drain) begin
      if (finish) m_fin = 1;
      if (wren) m_ovf = 1;
      if (!wrfull) begin
        mlog.push_back(mq.pop_front());
        if (mq.size() == 0) begin
          m_drain = 0;
          if (m_fin) m_done = 1;
        end
      end
    end else begin
      if (finish) m_fin = 1;
      if (wren) begin
        if (mq.size() < DEPTH) mq.push_back(wdata);
        else m_ovf = 1;
      end
      if (mq.size() == DEPTH || ((flush || finish) && mq.size() > 0)) m_drain = 1;
      else if (finish) m_done = 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic e_full, e_wren, e_done;
    e_full = rst ? 1'b0 : (m_done || m_drain || mq.size() == DEPTH);
    e_wren = rst ? 1'b0 : (m_drain && !wrfull);
    e_done = rst ? 1'b0 : m_done;
    chk("FULL", 32'(full), 32'(e_full));
    chk("FIFO_WREN", 32'(fwren), 32'(e_wren));
    chk("FIFO_DONE", 32'(fdone), 32'(e_done));
    if (e_wren) chk("FIFO_WRDATA", 32'(fdata), 32'(mq[0]));
    if (fwren === 1'b1) dlog.push_back(fdata);
`ifdef RING_COLLECT_OVERFLOW_EN
    chk("OVERFLOW", 32'(ovf), rst ? 32'd0 : 32'(m_ovf));
`endif
  end

  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic fl,
                     input logic fi, input logic wf);
    wren = w; wdata = d; flush = fl; finish = fi; wrfull = wf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    mlog.delete();
    dlog.delete();
  endtask

  task automatic check_log(input string name, input logic [WIDTH-1:0] exp[$]);
    bit ok_d, ok_m;
    ok_d = (dlog.size() == exp.size());
    ok_m = (mlog.size() == exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (ok_d && dlog[i] !== exp[i]) ok_d = 0;
      if (ok_m && mlog[i] !== exp[i]) ok_m = 0;
    end
    checks += 2;
    if (!ok_d) begin
      errors++;
      $display("FAIL %s dut stream: got %0d entries %p expected %p", name, dlog.size(), dlog, exp);
    end
    if (!ok_m) begin
      errors++;
      $display("FAIL %s model stream: got %0d entries %p expected %p", name, mlog.size(), mlog, exp);
    end
    mlog.delete();
    dlog.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] exp[$];
    do_reset();
    chk("reset FULL", 32'(full), 32'd0);
    chk("reset FIFO_DONE", 32'(fdone), 32'd0);

    // Four writes fill the buffer and drain in order.
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0);
    cyc(1, 8'h44, 0, 0, 0);
    chk("full after 4th write", 32'(full), 32'd1);
    idle(5);
    chk("full released", 32'(full), 32'd0);
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_log("fill_drain", exp);

    // Partial flush with a stalled downstream FIFO.
    cyc(1, 8'hA1, 0, 0, 0);
    cyc(1, 8'hA2, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("no emit while stalled", 32'(dlog.size()), 32'd0);
    idle(4);
    chk("back to fill", 32'(full), 32'd0);
    exp = '{8'hA1, 8'hA2};
    check_log("flush_stall", exp);

    // Write with FINISH in the same cycle.
    cyc(1, 8'h05, 0, 1, 0);
    idle(3);
    cyc(1, 8'h66, 0, 0, 0);
    cyc(1, 8'h67, 1, 0, 0);
    idle(2);
    chk("done sticky", 32'(fdone), 32'd1);
    exp = '{8'h05};
    check_log("write_finish", exp);

    // FINISH on an empty buffer.
    do_reset();
    cyc(0, 8'h00, 0, 1, 0);
    chk("empty finish done", 32'(fdone), 32'd1);
    idle(2);
    exp = '{};
    check_log("empty_finish", exp);

    // Write attempted during drain is dropped.
    do_reset();
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    cyc(1, 8'h33, 0, 0, 0);
    cyc(1, 8'h44, 0, 0, 0);
    cyc(1, 8'h99, 0, 0, 0);
    cyc(1, 8'h99, 0, 0, 0);
    idle(4);
`ifdef RING_COLLECT_OVERFLOW_EN
    chk("overflow set", 32'(ovf), 32'd1);
`endif
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    check_log("overflow_drop", exp);

    // Reset in the middle of a drain.
    do_reset();
    cyc(1, 8'hC1, 0, 0, 0);
    cyc(1, 8'hC2, 0, 0, 0);
    cyc(1, 8'hC3, 0, 0, 0);
    cyc(1, 8'hC4, 0, 0, 0);
    idle(2);
    rst = 1'b1;
    cyc(0, 8'h00, 0, 0, 0);
    rst = 1'b0;
    chk("post-reset FULL", 32'(full), 32'd0);
    chk("post-reset FIFO_WREN", 32'(fwren), 32'd0);
    cyc(1, 8'h7E, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    idle(3);
    exp = '{8'hC1, 8'hC2, 8'h7E};
    check_log("mid_drain_reset", exp);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ((m_done && $urandom_range(3) == 0) || $urandom_range(299) == 0);
      cyc($urandom_range(1), WIDTH'($urandom), $urandom_range(15) == 0,
          $urandom_range(63) == 0, $urandom_range(2) == 0);
    end
    rst = 1'b0;
    idle(12);
    checks++;
    if (dlog.size() != mlog.size()) begin
      errors++;
      $display("FAIL random stream length: got %0d expected %0d", dlog.size(), mlog.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
